// File: rtl/debounce_bank_if.sv
// debounce_bank_if: pin-side and event-side signals of the debounce bank.
//   sig_in     raw asynchronous button/switch pins, one bit per channel
//   sig_out    debounced level, same polarity as the pin
//   pressed    one-cycle pulse on entry to the pressed state
//   released   one-cycle pulse on exit from the pressed state
//   long_press one-cycle pulse once a press has lasted LONG_CYCLES
//   long_held  level, from the long_press cycle until release
// master = board side (drives pins, consumes events); slave = debouncer.
interface debounce_bank_if #(
    parameter int CHANNELS = 2
);
    logic [CHANNELS-1:0] sig_in;
    logic [CHANNELS-1:0] sig_out;
    logic [CHANNELS-1:0] pressed;
    logic [CHANNELS-1:0] released;
    logic [CHANNELS-1:0] long_press;
    logic [CHANNELS-1:0] long_held;

    modport master (
        output sig_in,
        input  sig_out, pressed, released, long_press, long_held
    );

    modport slave (
        input  sig_in,
        output sig_out, pressed, released, long_press, long_held
    );
endinterface

// File: rtl/debounce_bank.sv
// debounce_bank: CHANNELS independent button debouncers with edge pulses and
// long-press detection, clocked by clk25.
//   clk25  system clock
//   rst    asynchronous reset, active-high
//   bus    debounce_bank_if slave port (pins in, debounced level/events out)
// debounce_chan is the per-channel slice instantiated once per channel.

module debounce_chan #(
    parameter int STABLE_CYCLES = 250000,
    parameter int LONG_CYCLES   = 25000000,
    parameter bit ACTIVE_LOW    = 1'b1
) (
    input  logic clk25,
    input  logic rst,
    input  logic sig_i,
    output logic sig_o,
    output logic pressed_o,
    output logic released_o,
    output logic long_press_o,
    output logic long_held_o
);
    localparam logic IDLE = ACTIVE_LOW ? 1'b1 : 1'b0;
    localparam int   SW   = $clog2(STABLE_CYCLES + 1);
    localparam int   LW   = $clog2(LONG_CYCLES + 1);
    localparam logic [SW-1:0] STABLE_TC = SW'(STABLE_CYCLES - 1);
    localparam logic [LW-1:0] LONG_MAX  = LW'(LONG_CYCLES);
    localparam logic [LW-1:0] LONG_TC   = LW'(LONG_CYCLES - 1);

    logic          s1_q, s2_q;
    logic          level_q, level_d;
    logic [SW-1:0] stab_q, stab_d;
    logic [LW-1:0] long_q, long_d;
    logic          pressed_q, pressed_d;
    logic          released_q, released_d;
    logic          long_press_q, long_press_d;
    logic          long_held_q, long_held_d;
    logic          act_q, act_d;

    always_comb begin
        level_d = level_q;
        stab_d  = '0;
        // Any sample matching the current level restarts the filter.
        if (s2_q != level_q) begin
            if (stab_q == STABLE_TC) begin
                level_d = s2_q;
            end else begin
                stab_d = stab_q + SW'(1);
            end
        end

        act_q = (level_q != IDLE);
        act_d = (level_d != IDLE);

        // Pulses are computed from the next level so they line up with sig_o.
        pressed_d  = act_d && !act_q;
        released_d = act_q && !act_d;

        // Count only while pressed on both sides of the edge, so the counter
        // is back at zero the cycle released pulses; saturation means the
        // terminal compare can only hit once per press.
        long_d       = '0;
        long_press_d = 1'b0;
        if (act_q && act_d) begin
            long_d       = (long_q == LONG_MAX) ? long_q : long_q + LW'(1);
            long_press_d = (long_q == LONG_TC);
        end
        long_held_d = act_d && (long_held_q || long_press_d);
    end

    always_ff @(posedge clk25 or posedge rst) begin
        if (rst) begin
            s1_q         <= IDLE;
            s2_q         <= IDLE;
            level_q      <= IDLE;
            stab_q       <= '0;
            long_q       <= '0;
            pressed_q    <= 1'b0;
            released_q   <= 1'b0;
            long_press_q <= 1'b0;
            long_held_q  <= 1'b0;
        end else begin
            s1_q         <= sig_i;
            s2_q         <= s1_q;
            level_q      <= level_d;
            stab_q       <= stab_d;
            long_q       <= long_d;
            pressed_q    <= pressed_d;
            released_q   <= released_d;
            long_press_q <= long_press_d;
            long_held_q  <= long_held_d;
        end
    end

    assign sig_o        = level_q;
    assign pressed_o    = pressed_q;
    assign released_o   = released_q;
    assign long_press_o = long_press_q;
    assign long_held_o  = long_held_q;
endmodule

module debounce_bank #(
    parameter int CHANNELS      = 2,
    parameter int STABLE_CYCLES = 250000,
    parameter int LONG_CYCLES   = 25000000,
    parameter bit ACTIVE_LOW    = 1'b1
) (
    input  logic             clk25,
    input  logic             rst,
    debounce_bank_if.slave   bus
);
    logic [CHANNELS-1:0] sig_out_w;
    logic [CHANNELS-1:0] pressed_w;
    logic [CHANNELS-1:0] released_w;
    logic [CHANNELS-1:0] long_press_w;
    logic [CHANNELS-1:0] long_held_w;

    for (genvar c = 0; c < CHANNELS; c++) begin : g_ch
        debounce_chan #(
            .STABLE_CYCLES (STABLE_CYCLES),
            .LONG_CYCLES   (LONG_CYCLES),
            .ACTIVE_LOW    (ACTIVE_LOW)
        ) u_ch (
            .clk25        (clk25),
            .rst          (rst),
            .sig_i        (bus.sig_in[c]),
            .sig_o        (sig_out_w[c]),
            .pressed_o    (pressed_w[c]),
            .released_o   (released_w[c]),
            .long_press_o (long_press_w[c]),
            .long_held_o  (long_held_w[c])
        );
    end

    assign bus.sig_out    = sig_out_w;
    assign bus.pressed    = pressed_w;
    assign bus.released   = released_w;
    assign bus.long_press = long_press_w;
    assign bus.long_held  = long_held_w;
endmodule

// File: tb/tb_debounce_bank.sv
// tb_debounce_bank: scoreboard bench for debounce_bank with CHANNELS=2,
// STABLE_CYCLES=4, LONG_CYCLES=10, ACTIVE_LOW=1. Stimulus pushes every
// expected pulse cycle (with the output snapshot at that cycle) into a queue;
// a monitor pops one entry whenever any pulse output is high.
module tb_debounce_bank;
    logic clk25;
    logic rst;
    int   cyc    = 0;
    int   errors = 0;
    int   checks = 0;

    debounce_bank_if #(.CHANNELS(2)) bus ();

    debounce_bank #(
        .CHANNELS      (2),
        .STABLE_CYCLES (4),
        .LONG_CYCLES   (10),
        .ACTIVE_LOW    (1'b1)
    ) dut (
        .clk25 (clk25),
        .rst   (rst),
        .bus   (bus)
    );

    typedef struct {
        int         cyc;
        logic [1:0] pr;
        logic [1:0] rl;
        logic [1:0] lp;
        logic [1:0] lh;
        logic [1:0] so;
    } ev_t;

    ev_t exp_q[$];

    initial begin
        clk25 = 1'b0;
        forever #5 clk25 = ~clk25;
    end

    always @(posedge clk25) cyc <= cyc + 1;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic push(input int c, input logic [1:0] pr, input logic [1:0] rl,
                        input logic [1:0] lp, input logic [1:0] lh, input logic [1:0] so);
        ev_t e;
        e.cyc = c; e.pr = pr; e.rl = rl; e.lp = lp; e.lh = lh; e.so = so;
        exp_q.push_back(e);
    endtask

    task automatic wait_until(input int t);
        while (cyc < t) @(negedge clk25);
    endtask

    // Monitor: any pulse must match the head of the scoreboard.
    always @(negedge clk25) begin
        if ((bus.pressed | bus.released | bus.long_press) != 2'b00) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_pulse: cycle %0d pressed=%b released=%b long_press=%b, expected no pulse",
                         cyc, bus.pressed, bus.released, bus.long_press);
            end else begin
                ev_t e;
                e = exp_q.pop_front();
                chk("ev_cycle",      cyc,            e.cyc);
                chk("ev_pressed",    bus.pressed,    e.pr);
                chk("ev_released",   bus.released,   e.rl);
                chk("ev_long_press", bus.long_press, e.lp);
                chk("ev_long_held",  bus.long_held,  e.lh);
                chk("ev_sig_out",    bus.sig_out,    e.so);
                chk("ev_pr_rl_excl", bus.pressed & bus.released, 0);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, got timeout expected completion");
        $fatal(1);
    end

    initial begin
        int n;
        bus.sig_in = 2'b11;
        rst        = 1'b0;
        #1 rst = 1'b1;
        repeat (3) @(negedge clk25);
        chk("rst_sig_out",    bus.sig_out,    3);
        chk("rst_pressed",    bus.pressed,    0);
        chk("rst_released",   bus.released,   0);
        chk("rst_long_press", bus.long_press, 0);
        chk("rst_long_held",  bus.long_held,  0);
        rst = 1'b0;
        repeat (4) @(negedge clk25);
        #2 rst = 1'b1;
        #1 chk("rst_pulse_sig_out", bus.sig_out, 3);
        chk("rst_pulse_long_held", bus.long_held, 0);
        #1 rst = 1'b0;

        // Clean press held into a long press, then release.
        @(negedge clk25);
        n = cyc;
        bus.sig_in = 2'b10;
        push(n + 6,  2'b01, 2'b00, 2'b00, 2'b00, 2'b10);
        push(n + 16, 2'b00, 2'b00, 2'b01, 2'b01, 2'b10);
        wait_until(n + 5);
        chk("press_not_early", bus.sig_out, 3);
        wait_until(n + 6);
        chk("press_level", bus.sig_out, 2);
        wait_until(n + 15);
        chk("long_held_not_early", bus.long_held, 0);
        wait_until(n + 20);
        chk("long_held_set", bus.long_held, 1);
        n = cyc;
        bus.sig_in = 2'b11;
        push(n + 6, 2'b00, 2'b01, 2'b00, 2'b00, 2'b11);
        wait_until(n + 10);

        // Glitch rejection: 3 low, 1 high, 3 low, high.
        n = cyc;
        bus.sig_in = 2'b10;
        wait_until(n + 3); bus.sig_in = 2'b11;
        wait_until(n + 4); bus.sig_in = 2'b10;
        wait_until(n + 7); bus.sig_in = 2'b11;
        wait_until(n + 14);
        chk("glitch_level", bus.sig_out, 3);

        // Short press of 6 debounced cycles: no long_press.
        n = cyc;
        bus.sig_in = 2'b10;
        push(n + 6, 2'b01, 2'b00, 2'b00, 2'b00, 2'b10);
        wait_until(n + 6);
        bus.sig_in = 2'b11;
        push(n + 12, 2'b00, 2'b01, 2'b00, 2'b00, 2'b11);
        wait_until(n + 20);
        chk("short_long_held", bus.long_held, 0);

        // Both channels on the same edge.
        n = cyc;
        bus.sig_in = 2'b00;
        push(n + 6, 2'b11, 2'b00, 2'b00, 2'b00, 2'b00);
        wait_until(n + 8);
        bus.sig_in = 2'b11;
        push(n + 14, 2'b00, 2'b11, 2'b00, 2'b00, 2'b11);
        wait_until(n + 18);

        // Reset while long_held: everything clears without a clock edge.
        n = cyc;
        bus.sig_in = 2'b10;
        push(n + 6,  2'b01, 2'b00, 2'b00, 2'b00, 2'b10);
        push(n + 16, 2'b00, 2'b00, 2'b01, 2'b01, 2'b10);
        wait_until(n + 18);
        chk("pre_rst_long_held", bus.long_held, 1);
        bus.sig_in = 2'b11;
        #2 rst = 1'b1;
        #1 chk("async_rst_sig_out", bus.sig_out, 3);
        chk("async_rst_long_held", bus.long_held, 0);
        @(negedge clk25);
        @(negedge clk25);
        rst = 1'b0;
        repeat (10) @(negedge clk25);
        chk("post_rst_idle", bus.sig_out, 3);

        // Reset mid-filter on ch1 with the pin still held low.
        n = cyc;
        bus.sig_in = 2'b01;
        wait_until(n + 4);
        #2 rst = 1'b1;
        #1 chk("midfilt_rst_sig_out", bus.sig_out, 3);
        @(negedge clk25);
        @(negedge clk25);
        n = cyc;
        rst = 1'b0;
        push(n + 6, 2'b10, 2'b00, 2'b00, 2'b00, 2'b01);
        wait_until(n + 5);
        chk("midfilt_not_early", bus.sig_out, 3);
        wait_until(n + 10);

        chk("scoreboard_drained", exp_q.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
